// File: rtl/eros_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : eros_pwr_seq
// Description : Always-on power/clock sequencer for the EROS cluster. Steps
//               clock gate, bank retention, bank power switches and cluster
//               reset through an acknowledged power-down / power-up sequence.
//               Optional feature macro: EROS_PWR_RETENTION_EN (defined ->
//               retention steps used, cluster reset held high; undefined ->
//               retention skipped, cluster restarts cold).
// Revision    : 1.0 - initial release
// ============================================================================
module eros_pwr_seq #(
    parameter int unsigned NHARTS        = 3,
    parameter int unsigned N_BANKS       = 2,
    parameter int unsigned IDLE_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sleep_req_i,
    input  logic               wake_i,
    input  logic [NHARTS-1:0]  hart_sleep_i,
    output logic               en_o,
    output logic               eros_rst_no,
    output logic [N_BANKS-1:0] pwrgate_no,
    input  logic [N_BANKS-1:0] pwrgate_ack_ni,
    output logic [N_BANKS-1:0] set_retentive_no,
    output logic               busy_o,
    output logic               off_o,
    output logic               error_o,
    input  logic               error_clr_i
);

    // One shared dwell/idle/ack counter, wide enough for the largest limit.
    localparam int unsigned c_MAX_A   = (IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned c_MAX_LIM = (c_MAX_A > ACK_TIMEOUT) ? c_MAX_A : ACK_TIMEOUT;
    localparam int unsigned c_CNT_W   = $clog2(c_MAX_LIM) + 1;

    localparam logic [c_CNT_W-1:0] c_IDLE_LAST   = c_CNT_W'(IDLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ACK_LAST    = c_CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_ACTIVE    = 4'd0,
        S_IDLE_WAIT = 4'd1,
        S_CLK_OFF   = 4'd2,
        S_RET_ON    = 4'd3,
        S_PWR_OFF   = 4'd4,
        S_OFF       = 4'd5,
        S_PWR_ON    = 4'd6,
        S_RET_OFF   = 4'd7,
        S_CLK_ON    = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_wake_pend;
    logic                 w_wake_pend_nxt;
    logic                 w_all_asleep;
    logic                 w_ack_off;
    logic                 w_ack_on;
    logic                 w_settled;
    logic                 w_ack_expired;
    logic                 w_timeout;
    logic                 w_in_down;

    logic                 r_en;
    logic                 r_rst_n;
    logic                 r_pwr_n;
    logic                 r_ret_n;
    logic                 r_busy;
    logic                 r_off;
    logic                 r_error;
    logic                 w_en_nxt;
    logic                 w_rst_n_nxt;
    logic                 w_pwr_n_nxt;
    logic                 w_ret_n_nxt;
    logic                 w_busy_nxt;
    logic                 w_off_nxt;
    logic                 w_error_nxt;

    assign w_all_asleep  = &hart_sleep_i;
    assign w_ack_off     = ~|pwrgate_ack_ni;
    assign w_ack_on      = &pwrgate_ack_ni;
    assign w_settled     = (r_cnt == c_SETTLE_LAST);
    assign w_ack_expired = (r_cnt == c_ACK_LAST);
    assign w_in_down     = (r_state inside {S_CLK_OFF, S_RET_ON, S_PWR_OFF});

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_ACTIVE: begin
                if (sleep_req_i) begin
                    w_state_nxt = S_IDLE_WAIT;
                end
            end
            S_IDLE_WAIT: begin
                if (wake_i) begin
                    w_state_nxt = S_ACTIVE;
                end else if (w_all_asleep && (r_cnt == c_IDLE_LAST)) begin
                    w_state_nxt = S_CLK_OFF;
                end
            end
            S_CLK_OFF: begin
                if (w_settled) begin
`ifdef EROS_PWR_RETENTION_EN
                    w_state_nxt = S_RET_ON;
`else
                    w_state_nxt = S_PWR_OFF;
`endif
                end
            end
            S_RET_ON: begin
                if (w_settled) begin
                    w_state_nxt = S_PWR_OFF;
                end
            end
            S_PWR_OFF: begin
                if (w_ack_off) begin
                    w_state_nxt = S_OFF;
                end else if (w_ack_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_OFF;
                end
            end
            S_OFF: begin
                if (wake_i || r_wake_pend) begin
                    w_state_nxt = S_PWR_ON;
                end
            end
            S_PWR_ON: begin
                if (w_ack_on || w_ack_expired) begin
                    w_timeout = !w_ack_on;
`ifdef EROS_PWR_RETENTION_EN
                    w_state_nxt = S_RET_OFF;
`else
                    w_state_nxt = S_CLK_ON;
`endif
                end
            end
            S_RET_OFF: begin
                if (w_settled) begin
                    w_state_nxt = S_CLK_ON;
                end
            end
            S_CLK_ON: begin
                if (w_settled) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = S_ACTIVE;
            end
        endcase
    end

    // Counter restarts on every state change; in IDLE_WAIT it also restarts
    // whenever any hart is awake.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if ((r_state == S_IDLE_WAIT) && !w_all_asleep) begin
            w_cnt_nxt = '0;
        end else if (!(&r_cnt)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // A wake seen while powering down is remembered so OFF is left at once.
    assign w_wake_pend_nxt = w_in_down ? (r_wake_pend | wake_i) : 1'b0;

    // ------------------------------------------------------------------------
    // Output decode from the next state, so each change lands in the first
    // cycle of the state that makes it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_en_nxt    = !(w_state_nxt inside {S_CLK_OFF, S_RET_ON, S_PWR_OFF,
                                            S_OFF, S_PWR_ON, S_RET_OFF});
        w_pwr_n_nxt = !(w_state_nxt inside {S_PWR_OFF, S_OFF});
`ifdef EROS_PWR_RETENTION_EN
        w_ret_n_nxt = !(w_state_nxt inside {S_RET_ON, S_PWR_OFF, S_OFF, S_PWR_ON});
        w_rst_n_nxt = 1'b1;
`else
        w_ret_n_nxt = 1'b1;
        w_rst_n_nxt = !(w_state_nxt inside {S_PWR_OFF, S_OFF, S_PWR_ON, S_CLK_ON});
`endif
        w_busy_nxt  = !(w_state_nxt inside {S_ACTIVE, S_OFF});
        w_off_nxt   = (w_state_nxt == S_OFF);
        // A timeout in the same cycle as a clear keeps the flag set.
        w_error_nxt = r_error;
        if (w_timeout) begin
            w_error_nxt = 1'b1;
        end else if (error_clr_i) begin
            w_error_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_ACTIVE;
            r_cnt       <= '0;
            r_wake_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wake_pend <= w_wake_pend_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en    <= 1'b1;
            r_rst_n <= 1'b1;
            r_pwr_n <= 1'b1;
            r_ret_n <= 1'b1;
            r_busy  <= 1'b0;
            r_off   <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_en    <= w_en_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_pwr_n <= w_pwr_n_nxt;
            r_ret_n <= w_ret_n_nxt;
            r_busy  <= w_busy_nxt;
            r_off   <= w_off_nxt;
            r_error <= w_error_nxt;
        end
    end

    assign en_o             = r_en;
    assign eros_rst_no      = r_rst_n;
    assign pwrgate_no       = {N_BANKS{r_pwr_n}};
    assign set_retentive_no = {N_BANKS{r_ret_n}};
    assign busy_o           = r_busy;
    assign off_o            = r_off;
    assign error_o          = r_error;

endmodule
`default_nettype wire
